// File: rtl/param_mod_counter.sv
// param_mod_counter: up/down counter with a runtime modulus, synchronous load
// with range checking, a registered wrap pulse and a saturating wrap counter.
// A mod_val of zero selects the full 2^WIDTH range.
module param_mod_counter #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  mod_val,
  output logic [WIDTH-1:0]  q,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err
);

  // One extra bit so that a modulus of 2^WIDTH is representable in compares.
  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH-1:0]  q_q, q_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              load_err_q, load_err_d;

  logic [XW-1:0]     m_x;
  logic [XW-1:0]     q_x;
  logic [XW-1:0]     load_val_x;
  logic [WIDTH-1:0]  m_top;
  logic              q_illegal;
  logic              load_oob;

  // Effective modulus and range flags, all evaluated at WIDTH+1 bits.
  assign m_x        = (mod_val == '0) ? (XW'(1) << WIDTH) : {1'b0, mod_val};
  assign q_x        = {1'b0, q_q};
  assign load_val_x = {1'b0, load_val};
  // M-1 fits in WIDTH bits; mod_val = 0 wraps naturally to all ones = 2^WIDTH-1.
  assign m_top      = mod_val - WIDTH'(1);
  assign q_illegal  = (q_x >= m_x);
  assign load_oob   = (load_val_x >= m_x);

  // Next-state logic: load has priority over counting; pulses default low.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned, which would otherwise infer a latch.
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (load) begin
      if (load_oob) begin
        q_d        = '0;
        load_err_d = 1'b1;
      end else begin
        q_d = load_val;
      end
    end else if (en) begin
      if (up) begin
        // An out-of-range count recovers to 0 as if it had wrapped.
        if (q_illegal || (q_q == m_top)) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        // An out-of-range count recovers to M-1 as if it had wrapped.
        if (q_illegal || (q_q == '0)) begin
          q_d    = m_top;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // Wrap counter saturates at all ones instead of rolling over.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  // State registers with asynchronous clear of every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      load_err_q <= load_err_d;
    end
  end

  // Outputs come straight from registers: no input-to-output path.
  assign q        = q_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed testbench for param_mod_counter (WIDTH = 3). A second instance with
// WRAP_W = 2 shares the inputs and is used to observe wrap-counter saturation.
module tb_param_mod_counter;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic [7:0]       wrap_cnt;
  logic             load_err;

  logic [WIDTH-1:0] q2;
  logic             wrap2;
  logic [1:0]       wrap_cnt2;
  logic             load_err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(WIDTH), .WRAP_W(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .mod_val  (mod_val),
    .q        (q),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt),
    .load_err (load_err)
  );

  param_mod_counter #(.WIDTH(WIDTH), .WRAP_W(2)) u_dut_w2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .mod_val  (mod_val),
    .q        (q2),
    .wrap     (wrap2),
    .wrap_cnt (wrap_cnt2),
    .load_err (load_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse released on the following falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_q [8];
    exp_q = '{1, 2, 3, 4, 5, 6, 0, 1};

    reset    = 1'b1;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    mod_val  = 3'd7;

    // Reset state, forced without any clock edge.
    #2;
    check("rst_q",        q,        0);
    check("rst_wrap",     wrap,     0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_load_err", load_err, 0);

    // Count up modulo 7 for 8 edges.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("up7_q[%0d]", i),    q,    exp_q[i]);
      check($sformatf("up7_wrap[%0d]", i), wrap, (i == 6) ? 1 : 0);
    end
    check("up7_wrap_cnt", wrap_cnt, 1);

    // Full range (mod_val = 0) counting down from reset.
    mod_val = 3'd0;
    up      = 1'b0;
    do_reset();
    step();
    check("dn8_q0",    q,    7);
    check("dn8_wrap0", wrap, 1);
    step();
    check("dn8_q1",    q,    6);
    check("dn8_wrap1", wrap, 0);
    step();
    check("dn8_q2",    q,    5);
    check("dn8_cnt",   wrap_cnt, 1);

    // Loads against modulus 5, including both range boundaries.
    mod_val  = 3'd5;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 3'd6;
    step();
    check("ld6_q",   q,        0);
    check("ld6_err", load_err, 1);
    check("ld6_wrap", wrap,    0);
    load_val = 3'd3;
    step();
    check("ld3_q",   q,        3);
    check("ld3_err", load_err, 0);
    load_val = 3'd5;
    step();
    check("ld5_q",   q,        0);
    check("ld5_err", load_err, 1);
    load_val = 3'd4;
    step();
    check("ld4_q",   q,        4);
    check("ld4_err", load_err, 0);
    // Load and count together: only the load takes effect.
    load_val = 3'd1;
    en       = 1'b1;
    up       = 1'b1;
    step();
    check("ld_en_q",    q,    1);
    check("ld_en_wrap", wrap, 0);
    // Idle hold.
    load = 1'b0;
    en   = 1'b0;
    step();
    check("idle_q",    q,        1);
    check("idle_wrap", wrap,     0);
    check("idle_err",  load_err, 0);

    // Illegal state after lowering the modulus.
    mod_val  = 3'd7;
    load     = 1'b1;
    load_val = 3'd6;
    step();
    check("ill_ld_q", q, 6);
    load    = 1'b0;
    mod_val = 3'd4;
    step();
    check("ill_hold_q",    q,    6);
    check("ill_hold_wrap", wrap, 0);
    en = 1'b1;
    up = 1'b1;
    step();
    check("ill_up_q",    q,    0);
    check("ill_up_wrap", wrap, 1);
    en       = 1'b0;
    mod_val  = 3'd7;
    load     = 1'b1;
    load_val = 3'd6;
    step();
    check("ill_ld2_q", q, 6);
    load    = 1'b0;
    mod_val = 3'd4;
    en      = 1'b1;
    up      = 1'b0;
    step();
    check("ill_dn_q",    q,    3);
    check("ill_dn_wrap", wrap, 1);
    // Top of the full 2^WIDTH range wraps to 0.
    en       = 1'b0;
    mod_val  = 3'd0;
    load     = 1'b1;
    load_val = 3'd7;
    step();
    check("full_ld7_q",   q,        7);
    check("full_ld7_err", load_err, 0);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    step();
    check("full_up_q",    q,    0);
    check("full_up_wrap", wrap, 1);
    check("full_cnt",     wrap_cnt, 4);

    // Modulus 1: wrap stays high, 2-bit wrap counter saturates.
    mod_val = 3'd1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("m1_q[%0d]", i),    q,    0);
      check($sformatf("m1_wrap[%0d]", i), wrap, 1);
      if (i == 3) check("m1_cnt2_sat", wrap_cnt2, 3);
    end
    check("m1_q2",    q2,        0);
    check("m1_wrap2", wrap2,     1);
    check("m1_cnt2",  wrap_cnt2, 3);
    check("m1_cnt8",  wrap_cnt,  6);

    // Asynchronous reset between edges while q = 5.
    mod_val = 3'd7;
    en      = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ar_pre_q", q, 5);
    #3;
    reset = 1'b1;
    #1;
    check("ar_q",    q,        0);
    check("ar_wrap", wrap,     0);
    check("ar_cnt",  wrap_cnt, 0);
    // Load of an out-of-range value held in reset is discarded.
    en       = 1'b0;
    mod_val  = 3'd5;
    load     = 1'b1;
    load_val = 3'd6;
    step();
    check("ar_ld_q",   q,        0);
    check("ar_ld_err", load_err, 0);
    load    = 1'b0;
    mod_val = 3'd7;
    en      = 1'b1;
    up      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    check("ar_post_q1",   q,        1);
    check("ar_post_wrap", wrap,     0);
    check("ar_post_err",  load_err, 0);
    step();
    check("ar_post_q2",   q,        2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
